// File: rtl/trap_cause_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------------+
// | trap_cause_arbiter: sticky-pending trap arbiter with a valid/ack cause handoff |
// | Optional macro TRAP_PREEMPT_EN: a higher-priority source replaces the shown    |
// | cause. Rev 1.0                                                                 |
// +--------------------------------------------------------------------------------+
module trap_cause_arbiter #(
   parameter int NUM_SRC = 10,
   parameter int CAUSE_W = 4,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src_evt,
   input  logic [NUM_SRC-1:0] src_mask,
   output logic               trap_valid,
   output logic [CAUSE_W-1:0] trap_cause,
   input  logic               trap_ack,
   output logic [NUM_SRC-1:0] pending,
   output logic [CNT_W-1:0]   coalesce_cnt
);

   localparam int POP_W = $clog2(NUM_SRC + 1);
   localparam int SUM_W = CNT_W + POP_W;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } state_t;

   state_t             state;
   logic               ack_fire;
   logic [NUM_SRC-1:0] ack_clr;
   logic [NUM_SRC-1:0] coalesce_hit;
   logic [NUM_SRC-1:0] eligible;
   logic [POP_W-1:0]   coalesce_pop;
   logic [SUM_W-1:0]   cnt_sum;
   logic               win_any;
   logic [CAUSE_W-1:0] win_idx;
   logic               preempt;

   assign ack_fire = (state == ST_PRESENT) && trap_ack;

   // An event landing on the acked bit in the ack cycle is a fresh event, not a coalesce.
   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         ack_clr[i] = ack_fire && (trap_cause == CAUSE_W'(i));
      end
   end

   assign coalesce_hit = src_evt & pending & ~ack_clr;

   always_comb begin
      coalesce_pop = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         coalesce_pop = coalesce_pop + POP_W'(coalesce_hit[i]);
      end
   end

   assign cnt_sum  = SUM_W'(coalesce_cnt) + SUM_W'(coalesce_pop);
   assign eligible = pending & src_mask;
   assign win_any  = |eligible;

   // Scan downward so the lowest set index (highest priority) is left last.
   always_comb begin
      win_idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            win_idx = CAUSE_W'(i);
         end
      end
   end

`ifdef TRAP_PREEMPT_EN
   assign preempt = win_any && (win_idx < trap_cause);
`else
   assign preempt = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         pending      <= '0;
         trap_valid   <= 1'b0;
         trap_cause   <= '0;
         coalesce_cnt <= '0;
      end else begin
         pending <= (pending & ~ack_clr) | src_evt;
         if (cnt_sum > SUM_W'({CNT_W{1'b1}})) begin
            coalesce_cnt <= '1;
         end else begin
            coalesce_cnt <= cnt_sum[CNT_W-1:0];
         end

         case (state)
            ST_IDLE: begin
               trap_valid <= 1'b0;
               if (win_any) begin
                  trap_cause <= win_idx;
                  trap_valid <= 1'b1;
                  state      <= ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               if (trap_ack) begin
                  trap_valid <= 1'b0;
                  state      <= ST_IDLE;
               end else if (preempt) begin
                  trap_cause <= win_idx;
               end
            end
            default: begin
               trap_valid <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
